rv_ifetch: RTL and testbench

Instruction fetch stage of the 5-stage RISC-V pipeline. It sits between instruction memory and rv_decode.
- Owns the PC.
- Issues word reads to an instruction memory with 1-cycle synchronous read latency.
- Buffers returned instructions in a small queue, so decode back-pressure never loses an in-flight fetch.
- Accepts branch/jump redirects from execute with zero-bubble request restart.

---
 rtl/rv_ifetch_pkg.sv | 20 ++
 rtl/rv_fetch_queue.sv | 90 +++++++++
 rtl/rv_ifetch.sv | 137 +++++++++++++
 tb/tb_rv_ifetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ifetch_pkg.sv
// Shared types and constants for the rv_ifetch instruction fetch stage.
package rv_ifetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } t_fetch_entry;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } t_redirect;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries between imem response and decode.
// Head reads as {0, NOP} when empty so the fetch outputs stay defined.
module rv_fetch_queue
    import rv_ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  t_fetch_entry     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output t_fetch_entry     head,
    output logic             empty,
    output logic             full
);

    t_fetch_entry     mem_q [DEPTH];
    t_fetch_entry     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (empty) begin
            head.pc    = '0;
            head.instr = NOP_INSTR;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rv_ifetch.sv
// RISC-V instruction fetch stage: PC, imem issue, in-flight kill and fetch queue.
// Optional performance counters are enabled with the IFETCH_PERF_CNT_EN macro.
module rv_ifetch
    import rv_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    t_redirect        redir;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             q_push, q_pop, q_empty, q_full;
    logic [CNT_W-1:0] q_count;
    t_fetch_entry     q_head, q_push_data;
    logic [OCC_W-1:0] occ;

    assign redir.valid = redirect_valid;
    assign redir.pc    = word_align(redirect_pc);

    // A redirect kills the response returning in the same cycle.
    assign q_push            = inflight_q & ~redir.valid;
    assign q_pop             = if_valid & dec_ready;
    assign q_push_data.pc    = req_pc_q;
    assign q_push_data.instr = imem_rd_data;

    assign if_valid = ~q_empty;
    assign if_pc    = q_head.pc;
    assign if_instr = q_head.instr;

    // Slots that will be occupied once the outstanding response lands.
    assign occ = OCC_W'(q_count) - OCC_W'(q_pop) + OCC_W'(inflight_q);

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        if (rst_n) begin
            if (redir.valid) begin
                imem_req   = 1'b1;
                imem_addr  = redir.pc;
                pc_d       = redir.pc + 32'd4;
                req_pc_d   = redir.pc;
                inflight_d = 1'b1;
            end else if (occ < OCC_W'(QUEUE_DEPTH)) begin
                imem_req   = 1'b1;
                pc_d       = pc_q + 32'd4;
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    rv_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redir.valid),
        .count     (q_count),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full)
    );

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(q_push && q_full && !q_pop))
        else $error("rv_ifetch: fetch queue overflow");

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        fetch_cnt_d = sat_inc(fetch_cnt_q, q_pop);
        stall_cnt_d = sat_inc(stall_cnt_q, if_valid & ~dec_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv_ifetch.sv
// Scoreboard bench for rv_ifetch: directed fetch, stall, redirect, wrap and reset scenarios.
module tb_rv_ifetch;
    import rv_ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_rd_data = 32'h0;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_dec_ready = 1'b1;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    logic [31:0] w_perf_fetch_cnt, w_perf_stall_cnt;
`endif

    int           n_checks = 0;
    int           n_fail = 0;
    t_fetch_entry exp_q[$];
    t_fetch_entry sb_e;

    always #5 clk = ~clk;

    rv_ifetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rd_data   (imem_rd_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    rv_ifetch #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(2)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (w_imem_req),
        .imem_addr      (w_imem_addr),
        .imem_rd_data   (w_rd_data),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .dec_ready      (w_dec_ready),
        .if_valid       (w_if_valid),
        .if_pc          (w_if_pc),
        .if_instr       (w_if_instr)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (w_perf_fetch_cnt),
        .perf_stall_cnt (w_perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00A0_0093;
            32'h0000_0004: return 32'h0140_0113;
            32'h0000_0008: return 32'h0020_81B3;
            default:       return {8'h13, a[23:0]};
        endcase
    endfunction

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rd_data <= imem_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'h0, act}, {31'h0, exp});
    endtask

    task automatic sb_push(input logic [31:0] p, input logic [31:0] i);
        exp_q.push_back(t_fetch_entry'{pc: p, instr: i});
    endtask

    // Every instruction handed to decode must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && if_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected no delivery", if_pc, if_instr);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_pc", if_pc, sb_e.pc);
                check("sb_instr", if_instr, sb_e.instr);
            end
        end
    end

    task automatic step(input logic dr, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #1;
        dec_ready      = dr;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    task automatic release_reset(input logic dr);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        dec_ready      = dr;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check1("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check1("rst_valid", if_valid, 1'b0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, NOP_INSTR);
        check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);

        // Streaming fetch with decode always ready, then fill the queue.
        sb_push(32'h0, 32'h00A0_0093);
        sb_push(32'h4, 32'h0140_0113);
        sb_push(32'h8, 32'h0020_81B3);
        release_reset(1'b1);
        check1("a0_req", imem_req, 1'b1);
        check("a0_addr", imem_addr, 32'h0);
        check1("a0_valid", if_valid, 1'b0);
        check1("a0_wrap_req", w_imem_req, 1'b1);
        check("a0_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        check("a1_addr", imem_addr, 32'h4);
        check1("a1_valid", if_valid, 1'b0);
        check("a1_wrap_addr", w_imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("a2_addr", imem_addr, 32'h8);
        check1("a2_valid", if_valid, 1'b1);
        check1("a2_wrap_valid", w_if_valid, 1'b1);
        check("a2_wrap_pc", w_if_pc, 32'hFFFF_FFFC);
        check("a2_wrap_instr", w_if_instr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check1("a3_valid", if_valid, 1'b1);
        check("a3_wrap_pc", w_if_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check1("a6_full_req", imem_req, 1'b0);
        check("a6_head_pc", if_pc, 32'hC);
        step(1'b0, 1'b0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check1("mrst_valid", if_valid, 1'b0);
        check1("mrst_req", imem_req, 1'b0);
        check("mrst_pc", if_pc, 32'h0);
        check("mrst_instr", if_instr, NOP_INSTR);
        check("mrst_addr", imem_addr, 32'h0);
        check("a_drained", exp_q.size(), 32'd0);

        // Five-cycle decode stall after the first delivery.
        sb_push(32'h0, 32'h00A0_0093);
        sb_push(32'h4, 32'h0140_0113);
        sb_push(32'h8, 32'h0020_81B3);
        sb_push(32'hC, 32'h1300_000C);
        release_reset(1'b1);
        check("b0_addr", imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("b2_pc", if_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check1("b_stall_valid", if_valid, 1'b1);
            check1("b_stall_req", imem_req, 1'b0);
        end
        check("b7_pc", if_pc, 32'h4);
        step(1'b1, 1'b0, 32'h0);
        check1("b8_req", imem_req, 1'b1);
        check("b8_addr", imem_addr, 32'hC);
`ifdef IFETCH_PERF_CNT_EN
        check("b8_stall_cnt", perf_stall_cnt, 32'd5);
        check("b8_fetch_cnt", perf_fetch_cnt, 32'd1);
`endif
        step(1'b1, 1'b0, 32'h0);
        check1("b9_valid", if_valid, 1'b1);
        check("b9_pc", if_pc, 32'h8);
        step(1'b1, 1'b0, 32'h0);
        check1("b10_valid", if_valid, 1'b1);
        check("b10_pc", if_pc, 32'hC);
        step(1'b0, 1'b0, 32'h0);
        check("b_drained", exp_q.size(), 32'd0);

        // Redirects: flush with full queue, unaligned target, back-to-back.
        sb_push(32'h0, 32'h00A0_0093);
        sb_push(32'h4, 32'h0140_0113);
        sb_push(32'h40, 32'h1300_0040);
        sb_push(32'h44, 32'h1300_0044);
        sb_push(32'h40, 32'h1300_0040);
        sb_push(32'h44, 32'h1300_0044);
        sb_push(32'h100, 32'h1300_0100);
        sb_push(32'h104, 32'h1300_0104);
        release_reset(1'b1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h40);
        check1("c5_req", imem_req, 1'b1);
        check("c5_addr", imem_addr, 32'h40);
        check1("c5_valid", if_valid, 1'b1);
        check("c5_old_head", if_pc, 32'h8);
        step(1'b1, 1'b0, 32'h0);
        check1("c6_flushed", if_valid, 1'b0);
        check("c6_addr", imem_addr, 32'h44);
        step(1'b1, 1'b0, 32'h0);
        check("c7_pc", if_pc, 32'h40);
        step(1'b1, 1'b1, 32'h43);
        check("c8_aligned_addr", imem_addr, 32'h40);
        check("c8_head", if_pc, 32'h44);
        step(1'b1, 1'b0, 32'h0);
        check1("c9_valid", if_valid, 1'b0);
        step(1'b1, 1'b0, 32'h0);
        check("c10_pc", if_pc, 32'h40);
        step(1'b1, 1'b1, 32'h80);
        check("c11_addr", imem_addr, 32'h80);
        step(1'b1, 1'b1, 32'h100);
        check("c12_addr", imem_addr, 32'h100);
        check1("c12_valid", if_valid, 1'b0);
        step(1'b1, 1'b0, 32'h0);
        check1("c13_valid", if_valid, 1'b0);
        step(1'b1, 1'b0, 32'h0);
        check("c14_pc", if_pc, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        check("c15_pc", if_pc, 32'h104);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("c_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
